mem_to_fifo: RTL and testbench
==============================

# mem_to_fifo

Read-side counterpart of the QDR write path in the pcap replay micro-engine. It streams a stored capture from QDR SRAM, word range MEM_ADDR_LOW..mem_addr_high-1, into the replay output FIFO, replaying the range a programmable number of times. Outstanding read beats are bounded by a credit counter, so returned data is never dropped for lack of FIFO space.

## Interface
Parameters:
- FIFO_DATA_WIDTH, 72: output FIFO word; equals 2*MEM_DATA_WIDTH.
- MEM_ADDR_WIDTH, 19: QDR address width.
- MEM_DATA_WIDTH, 36: QDR half-word width.
- MEM_BURST_LENGTH, 2: 2 or 4; one FIFO word or two FIFO words per read command.
- MEM_ADDR_LOW, 0: first FIFO-word index of the capture.
- MAX_OUTSTANDING, 8: maximum in-flight read beats (one beat = one FIFO word).
- REPLAY_CNT_WIDTH, 32: width of replay_cnt.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- fifo_wr_en, out, 1: push fifo_data.
- fifo_data, out, FIFO_DATA_WIDTH: {mem_qrh, mem_qrl}.
- fifo_nearly_full, in, 1: high when FIFO free space ≤ MAX_OUTSTANDING words.
- mem_r_n, out, 1: read command strobe, active-low.
- mem_ad_rd, out, MEM_ADDR_WIDTH: read address.
- mem_rd_full, in, 1: controller read command queue full.
- mem_dr_valid, in, 1: read beat valid.
- mem_qrl, in, MEM_DATA_WIDTH: low half of beat.
- mem_qrh, in, MEM_DATA_WIDTH: high half of beat.
- mem_addr_high, in, MEM_ADDR_WIDTH+1: end index, exclusive, in FIFO words.
- replay_cnt, in, REPLAY_CNT_WIDTH: passes over the range; 0 = loop until sw_rst.
- start, in, 1: one-cycle pulse; sampled only in IDLE.
- sw_rst, in, 1: software abort.
- cal_done, in, 1: QDR calibration complete.
- busy, out, 1: state ≠ IDLE.
- done, out, 1: one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE: start && cal_done → READ. Load word_ptr = MEM_ADDR_LOW and passes_left = replay_cnt.
  - READ: issue reads (conditions below).
  - DRAIN: wait for outstanding == 0, then pulse done and → IDLE.
  - FLUSH: discard returned beats until outstanding == 0, then → IDLE with no done.
- Issue condition, evaluated in READ only: cal_done && !mem_rd_full && !fifo_nearly_full && outstanding + B ≤ MAX_OUTSTANDING, where B = MEM_BURST_LENGTH/2.
- On issue:
  - Register mem_r_n = 0 and mem_ad_rd = word_ptr (BL2) or word_ptr[MEM_ADDR_WIDTH:1] (BL4).
  - word_ptr += B.
  - outstanding += B.
- Each mem_dr_valid: outstanding -= 1. If the same cycle also issues, net = +B-1.
- In BL4, bit 0 of mem_addr_high is ignored, so the range is rounded down to even. word_ptr stays even.
- End of pass, when word_ptr+B ≥ end on issue:
  - If replay_cnt == 0 or passes_left > 1: word_ptr wraps to MEM_ADDR_LOW, and passes_left decrements when nonzero.
  - Otherwise → DRAIN.
- Empty range (end ≤ MEM_ADDR_LOW) or replay_cnt = 1 with empty range: IDLE → DRAIN directly, and done pulses once outstanding is 0.
- Data path: fifo_wr_en <= mem_dr_valid, and fifo_data <= {mem_qrh, mem_qrl}. Both are suppressed in FLUSH and IDLE.
- sw_rst, any state other than IDLE: → FLUSH immediately, and no further commands issue. sw_rst in IDLE has no effect.
- cal_done low mid-READ: issue pauses. Pointer and credits are held.
- outstanding is MAX_OUTSTANDING-sized, log2(MAX_OUTSTANDING+1) bits, and never underflows. A beat with outstanding == 0 is ignored.

## Timing
- Reset values: mem_r_n = 1, mem_ad_rd = 0, fifo_wr_en = 0, fifo_data = 0, busy = 0, done = 0. State IDLE, outstanding 0.
- start → first mem_r_n low: 2 cycles (state update, then registered command) when issue conditions hold.
- Back-to-back commands every cycle while conditions hold. Sustained rate is limited by MAX_OUTSTANDING versus memory read latency.
- mem_dr_valid → fifo_wr_en: 1 cycle.
- done asserts the cycle after outstanding reaches 0 in DRAIN.
- Reservation rule: fifo_nearly_full is sampled at issue time. This reservation guarantees space for every in-flight beat.

## Structure
- Shared package pcap_replay_pkg holds:
  - state enum: IDLE, READ, DRAIN, FLUSH;
  - the burst-to-beat constant B;
  - the clog2 function shared with the write side.
- One sub-module, rd_credit_ctr: a saturating up/down counter with issue(+B), return(−1), clear and a can_issue output.

## Test plan
- BL2, range 0..4, replay_cnt 1, no backpressure → commands at addresses 0,1,2,3. FIFO receives the 4 beats in order. done pulses once and busy drops.
- BL4, mem_addr_high 9, replay_cnt 2 → addresses 0,1,2,3,0,1,2,3 (end rounded down to 8). 16 FIFO writes, then done.
- MAX_OUTSTANDING 4, memory latency 20 cycles → never more than 4 beats in flight. Commands stall until beats return, and no beat is lost.
- fifo_nearly_full held high for 50 cycles mid-pass → no commands during the hold. Issue resumes the cycle after deassert, at the same address.
- sw_rst with 3 beats in flight → FLUSH. Those 3 beats are not written, the block returns to IDLE with no done, and a subsequent start restarts at MEM_ADDR_LOW.
- replay_cnt 0, range 0..2 → continuous addresses 0,1,0,1… until sw_rst. mem_rd_full asserted for 1 cycle stalls exactly 1 command.

Source files
------------

// File: rtl/pcap_replay_pkg.sv
// Shared definitions for the pcap replay QDR read/write paths.
package pcap_replay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // FIFO words (beats) delivered by one read command of the given burst length
    function automatic int unsigned burst_beats(input int unsigned burst_length);
        return burst_length / 2;
    endfunction

    // Ceiling log2, never below 1 so it can size a counter directly
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rd_credit_ctr.sv
// Saturating count of in-flight read beats; gates new commands on free credit.
module rd_credit_ctr
    import pcap_replay_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned BEATS = 1,
    localparam int unsigned CW = clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          issue,
    input  logic          ret,
    output logic [CW-1:0] count,
    output logic          can_issue_c
);

    localparam int unsigned SW = CW + 1;

    logic [SW-1:0] sum_c;
    logic          take_c;
    logic          give_c;

    // One extra bit of headroom so +BEATS cannot wrap before the saturation check
    always_comb begin
        can_issue_c = (SW'(count) + SW'(BEATS)) <= SW'(MAX_OUTSTANDING);
        take_c      = issue && can_issue_c;
        give_c      = ret && (count != '0);
        sum_c       = SW'(count);
        if (take_c) sum_c = sum_c + SW'(BEATS);
        if (give_c) sum_c = sum_c - SW'(1);
        if (sum_c > SW'(MAX_OUTSTANDING)) sum_c = SW'(MAX_OUTSTANDING);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else              count <= CW'(sum_c);
    end

endmodule

// File: rtl/mem_to_fifo.sv
// Replays a stored capture from QDR SRAM into the output FIFO, credit-limited
// so every returned beat already has FIFO space reserved.
module mem_to_fifo
    import pcap_replay_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH  = 72,
    parameter int unsigned MEM_ADDR_WIDTH   = 19,
    parameter int unsigned MEM_DATA_WIDTH   = 36,
    parameter int unsigned MEM_BURST_LENGTH = 2,
    parameter int unsigned MEM_ADDR_LOW     = 0,
    parameter int unsigned MAX_OUTSTANDING  = 8,
    parameter int unsigned REPLAY_CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0]  fifo_data,
    input  logic                        fifo_nearly_full,
    output logic                        mem_r_n,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_ad_rd,
    input  logic                        mem_rd_full,
    input  logic                        mem_dr_valid,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_qrl,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_qrh,
    input  logic [MEM_ADDR_WIDTH:0]     mem_addr_high,
    input  logic [REPLAY_CNT_WIDTH-1:0] replay_cnt,
    input  logic                        start,
    input  logic                        sw_rst,
    input  logic                        cal_done,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned B  = burst_beats(MEM_BURST_LENGTH);
    localparam int unsigned CW = clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = MEM_ADDR_WIDTH + 1;

    state_t                      state;
    logic [PW-1:0]               word_ptr;
    logic [REPLAY_CNT_WIDTH-1:0] passes_left;
    logic [CW-1:0]               outstanding;
    logic [PW-1:0]               end_ptr_c;
    logic [PW-1:0]               ptr_step_c;
    logic                        can_issue_c;
    logic                        issue_c;
    logic                        last_c;
    logic                        empty_c;
    logic                        beat_c;
    logic                        wr_c;

    rd_credit_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .BEATS           (B)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == IDLE),
        .issue       (issue_c),
        .ret         (mem_dr_valid),
        .count       (outstanding),
        .can_issue_c (can_issue_c)
    );

    // Two-beat bursts address FIFO-word pairs, so the end index is rounded down to even
    always_comb begin
        end_ptr_c  = (B == 2) ? {mem_addr_high[PW-1:1], 1'b0} : mem_addr_high;
        empty_c    = end_ptr_c <= PW'(MEM_ADDR_LOW);
        ptr_step_c = word_ptr + PW'(B);
        last_c     = ptr_step_c >= end_ptr_c;
        issue_c    = (state == READ) && cal_done && !sw_rst && !mem_rd_full
                     && !fifo_nearly_full && can_issue_c;
        beat_c     = mem_dr_valid && (outstanding != '0);
        wr_c       = beat_c && !sw_rst && ((state == READ) || (state == DRAIN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_ptr    <= PW'(MEM_ADDR_LOW);
            passes_left <= '0;
            mem_r_n     <= 1'b1;
            mem_ad_rd   <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_r_n    <= !issue_c;
            done       <= 1'b0;
            fifo_wr_en <= wr_c;
            if (wr_c) fifo_data <= FIFO_DATA_WIDTH'({mem_qrh, mem_qrl});

            // passes_left == 0 means endless replay, == 1 means this is the final pass
            if (issue_c) begin
                mem_ad_rd <= (B == 2) ? word_ptr[PW-1:1] : word_ptr[MEM_ADDR_WIDTH-1:0];
                if (!last_c) begin
                    word_ptr <= ptr_step_c;
                end else if (passes_left != REPLAY_CNT_WIDTH'(1)) begin
                    word_ptr <= PW'(MEM_ADDR_LOW);
                    if (passes_left != '0) passes_left <= passes_left - REPLAY_CNT_WIDTH'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start && cal_done) begin
                        word_ptr    <= PW'(MEM_ADDR_LOW);
                        passes_left <= replay_cnt;
                        busy        <= 1'b1;
                        state       <= empty_c ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (sw_rst) state <= FLUSH;
                    else if (issue_c && last_c && (passes_left == REPLAY_CNT_WIDTH'(1)))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (sw_rst) begin
                        state <= FLUSH;
                    end else if (outstanding == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (outstanding == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_to_fifo.sv
// Directed bench: instance a is BL2 with 4 credits, instance b is BL4 with 8 credits.
module tb_mem_to_fifo;

    localparam int unsigned MAW = 19;
    localparam int unsigned MDW = 36;
    localparam int unsigned FDW = 72;
    localparam int unsigned RCW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           cal_done = 1'b1;
    logic           sw_rst = 1'b0;
    logic           fifo_nearly_full = 1'b0;
    logic           mem_rd_full = 1'b0;
    logic [MAW:0]   mem_addr_high = '0;
    logic [RCW-1:0] replay_cnt = '0;

    logic           a_start = 1'b0, a_wr_en, a_r_n, a_busy, a_done;
    logic [FDW-1:0] a_data;
    logic [MAW-1:0] a_ad;
    logic           a_dr_valid = 1'b0;
    logic [MDW-1:0] a_qrl = '0, a_qrh = '0;

    logic           b_start = 1'b0, b_wr_en, b_r_n, b_busy, b_done;
    logic [FDW-1:0] b_data;
    logic [MAW-1:0] b_ad;
    logic           b_dr_valid = 1'b0;
    logic [MDW-1:0] b_qrl = '0, b_qrh = '0;

    mem_to_fifo #(.MEM_BURST_LENGTH(2), .MAX_OUTSTANDING(4)) u_a (
        .clk(clk), .rst(rst), .fifo_wr_en(a_wr_en), .fifo_data(a_data),
        .fifo_nearly_full(fifo_nearly_full), .mem_r_n(a_r_n), .mem_ad_rd(a_ad),
        .mem_rd_full(mem_rd_full), .mem_dr_valid(a_dr_valid), .mem_qrl(a_qrl),
        .mem_qrh(a_qrh), .mem_addr_high(mem_addr_high), .replay_cnt(replay_cnt),
        .start(a_start), .sw_rst(sw_rst), .cal_done(cal_done), .busy(a_busy), .done(a_done)
    );

    mem_to_fifo #(.MEM_BURST_LENGTH(4), .MAX_OUTSTANDING(8)) u_b (
        .clk(clk), .rst(rst), .fifo_wr_en(b_wr_en), .fifo_data(b_data),
        .fifo_nearly_full(fifo_nearly_full), .mem_r_n(b_r_n), .mem_ad_rd(b_ad),
        .mem_rd_full(mem_rd_full), .mem_dr_valid(b_dr_valid), .mem_qrl(b_qrl),
        .mem_qrh(b_qrh), .mem_addr_high(mem_addr_high), .replay_cnt(replay_cnt),
        .start(b_start), .sw_rst(sw_rst), .cal_done(cal_done), .busy(b_busy), .done(b_done)
    );

    // Stored capture contents: FIFO word index -> QDR halves
    function automatic logic [MDW-1:0] lo_of(input int idx);
        return MDW'(idx * 3 + 5);
    endfunction
    function automatic logic [MDW-1:0] hi_of(input int idx);
        return MDW'(idx + 'h800);
    endfunction
    function automatic logic [FDW-1:0] word_of(input int idx);
        return {hi_of(idx), lo_of(idx)};
    endfunction

    int cyc = 0;
    int lat = 3;
    int a_due[$], a_idx[$], a_cmds[$];
    int b_due[$], b_idx[$], b_cmds[$];
    logic [FDW-1:0] a_fifo[$], b_fifo[$];
    int a_inflight = 0;
    int a_done_cnt = 0, b_done_cnt = 0;

    // Memory responder and output logger, one beat per cycle per instance
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (a_wr_en) a_fifo.push_back(a_data);
        if (b_wr_en) b_fifo.push_back(b_data);
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
        a_dr_valid = 1'b0;
        if (a_due.size() > 0 && a_due[0] <= cyc) begin
            a_dr_valid = 1'b1;
            a_qrl = lo_of(a_idx[0]);
            a_qrh = hi_of(a_idx[0]);
            void'(a_due.pop_front());
            void'(a_idx.pop_front());
            a_inflight--;
        end
        if (!a_r_n) begin
            a_cmds.push_back(int'(a_ad));
            a_due.push_back(cyc + lat);
            a_idx.push_back(int'(a_ad));
            a_inflight++;
        end
        b_dr_valid = 1'b0;
        if (b_due.size() > 0 && b_due[0] <= cyc) begin
            b_dr_valid = 1'b1;
            b_qrl = lo_of(b_idx[0]);
            b_qrh = hi_of(b_idx[0]);
            void'(b_due.pop_front());
            void'(b_idx.pop_front());
        end
        if (!b_r_n) begin
            b_cmds.push_back(int'(b_ad));
            b_due.push_back(cyc + lat);
            b_idx.push_back(2 * int'(b_ad));
            b_due.push_back(cyc + lat + 1);
            b_idx.push_back(2 * int'(b_ad) + 1);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int peak = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input bit use_b, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (a_inflight > peak) peak = a_inflight;
            if ((use_b ? b_done : a_done) == 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    function automatic int cmds_bad(input int q[$], input int base, input int n, input int m);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (base + i >= q.size() || q[base + i] != i % m) bad++;
        return bad;
    endfunction

    function automatic int fifo_bad(input logic [FDW-1:0] q[$], input int base, input int n,
                                    input int m);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (base + i >= q.size() || q[base + i] !== word_of(i % m)) bad++;
        return bad;
    endfunction

    initial begin
        bit seen;
        int bc, bf, dc, n0, gaps, cnt;

        // Reset values
        tick(3);
        check("rst_mem_r_n", int'(a_r_n), 1);
        check("rst_mem_ad_rd", int'(a_ad), 0);
        check("rst_fifo_wr_en", int'(a_wr_en), 0);
        check("rst_fifo_data_nonzero", int'(a_data != '0), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_b_mem_r_n", int'(b_r_n), 1);
        rst = 1'b0;
        tick(2);

        // BL2, range 0..4, one pass
        lat = 3; mem_addr_high = (MAW+1)'(4); replay_cnt = RCW'(1);
        bc = a_cmds.size(); bf = a_fifo.size(); dc = a_done_cnt;
        a_start = 1'b1; tick(1); a_start = 1'b0;
        check("t1_busy_after_start", int'(a_busy), 1);
        check("t1_no_cmd_yet", int'(a_r_n), 1);
        tick(1);
        check("t1_first_cmd", int'(a_r_n), 0);
        check("t1_first_addr", int'(a_ad), 0);
        wait_done(1'b0, 100, seen);
        check("t1_done_seen", int'(seen), 1);
        check("t1_busy_cleared", int'(a_busy), 0);
        tick(5);
        check("t1_cmd_count", a_cmds.size() - bc, 4);
        check("t1_cmd_addrs", cmds_bad(a_cmds, bc, 4, 4), 0);
        check("t1_fifo_count", a_fifo.size() - bf, 4);
        check("t1_fifo_data", fifo_bad(a_fifo, bf, 4, 4), 0);
        check("t1_done_pulses", a_done_cnt - dc, 1);

        // Empty range goes straight to completion
        mem_addr_high = '0; bc = a_cmds.size();
        a_start = 1'b1; tick(1); a_start = 1'b0;
        wait_done(1'b0, 20, seen);
        check("te_done_seen", int'(seen), 1);
        check("te_no_cmds", a_cmds.size() - bc, 0);

        // Long memory latency: credits cap in-flight beats at 4
        lat = 20; mem_addr_high = (MAW+1)'(12); peak = 0;
        bc = a_cmds.size(); bf = a_fifo.size();
        a_start = 1'b1; tick(1); a_start = 1'b0;
        wait_done(1'b0, 600, seen);
        check("t3_done_seen", int'(seen), 1);
        check("t3_peak_inflight", peak, 4);
        check("t3_cmd_count", a_cmds.size() - bc, 12);
        check("t3_cmd_addrs", cmds_bad(a_cmds, bc, 12, 12), 0);
        tick(2);
        check("t3_fifo_count", a_fifo.size() - bf, 12);
        check("t3_fifo_data", fifo_bad(a_fifo, bf, 12, 12), 0);

        // fifo_nearly_full hold mid-pass
        lat = 3; mem_addr_high = (MAW+1)'(40);
        bc = a_cmds.size(); bf = a_fifo.size();
        a_start = 1'b1; tick(1); a_start = 1'b0;
        for (int i = 0; i < 50 && (a_cmds.size() - bc) < 5; i++) tick(1);
        fifo_nearly_full = 1'b1;
        tick(2);
        n0 = a_cmds.size();
        tick(48);
        check("t4_no_cmd_in_hold", a_cmds.size(), n0);
        fifo_nearly_full = 1'b0;
        tick(1);
        check("t4_resume_cmd", int'(a_r_n), 0);
        check("t4_resume_addr", int'(a_ad), n0 - bc);
        wait_done(1'b0, 400, seen);
        check("t4_done_seen", int'(seen), 1);
        tick(2);
        check("t4_cmd_addrs", cmds_bad(a_cmds, bc, 40, 40), 0);
        check("t4_fifo_count", a_fifo.size() - bf, 40);
        check("t4_fifo_data", fifo_bad(a_fifo, bf, 40, 40), 0);

        // Software abort with three beats in flight
        lat = 20; mem_addr_high = (MAW+1)'(12);
        bc = a_cmds.size(); bf = a_fifo.size(); dc = a_done_cnt; cnt = 0;
        a_start = 1'b1; tick(1); a_start = 1'b0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            tick(1);
            if (!a_r_n) cnt++;
        end
        sw_rst = 1'b1; tick(1); sw_rst = 1'b0;
        check("t5_busy_in_flush", int'(a_busy), 1);
        for (int i = 0; i < 100 && a_busy; i++) tick(1);
        check("t5_busy_cleared", int'(a_busy), 0);
        tick(25);
        check("t5_cmd_count", a_cmds.size() - bc, 3);
        check("t5_no_fifo_writes", a_fifo.size() - bf, 0);
        check("t5_no_done", a_done_cnt - dc, 0);
        lat = 3; bf = a_fifo.size();
        a_start = 1'b1; tick(1); a_start = 1'b0;
        tick(1);
        check("t5_restart_cmd", int'(a_r_n), 0);
        check("t5_restart_addr", int'(a_ad), 0);
        wait_done(1'b0, 200, seen);
        check("t5_restart_done", int'(seen), 1);
        tick(2);
        check("t5_restart_fifo", fifo_bad(a_fifo, bf, 12, 12), 0);

        // Endless replay over 0..2 with a one-cycle command-queue-full stall
        lat = 1; mem_addr_high = (MAW+1)'(2); replay_cnt = '0;
        bc = a_cmds.size(); dc = a_done_cnt; gaps = 0;
        a_start = 1'b1; tick(1); a_start = 1'b0;
        tick(10);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) mem_rd_full = 1'b1;
            if (i == 6) mem_rd_full = 1'b0;
            tick(1);
            if (a_r_n) gaps++;
        end
        check("t6_stall_cycles", gaps, 1);
        sw_rst = 1'b1; tick(1); sw_rst = 1'b0;
        check("t6_cmd_count", a_cmds.size() - bc, 29);
        check("t6_cmd_alternate", cmds_bad(a_cmds, bc, a_cmds.size() - bc, 2), 0);
        for (int i = 0; i < 50 && a_busy; i++) tick(1);
        check("t6_busy_cleared", int'(a_busy), 0);
        check("t6_no_done", a_done_cnt - dc, 0);

        // BL4, end 9 rounds down to 8, two passes
        lat = 3; mem_addr_high = (MAW+1)'(9); replay_cnt = RCW'(2);
        bc = b_cmds.size(); bf = b_fifo.size(); dc = b_done_cnt;
        b_start = 1'b1; tick(1); b_start = 1'b0;
        wait_done(1'b1, 300, seen);
        check("t2_done_seen", int'(seen), 1);
        check("t2_busy_cleared", int'(b_busy), 0);
        tick(5);
        check("t2_cmd_count", b_cmds.size() - bc, 8);
        check("t2_cmd_addrs", cmds_bad(b_cmds, bc, 8, 4), 0);
        check("t2_fifo_count", b_fifo.size() - bf, 16);
        check("t2_fifo_data", fifo_bad(b_fifo, bf, 16, 8), 0);
        check("t2_done_pulses", b_done_cnt - dc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
